// File: rtl/cpu_ctrl_fsm_pkg.sv
// cpu_ctrl_fsm_pkg: shared state, condition-code, PC-source encodings and instruction-class helpers.
package cpu_ctrl_fsm_pkg;
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_e;
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;
  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [3:0] OPC_CMP_LO = 4'h8;
  localparam logic [3:0] OPC_CMP_HI = 4'hB;
  // Class helpers take IR[27:24]; compare helper takes the opcode IR[24:21].
  function automatic logic is_dp(input logic [3:0] cls);
    return cls[3:2] == 2'b00;
  endfunction
  function automatic logic is_br(input logic [3:0] cls);
    return cls[3:1] == 3'b101;
  endfunction
  function automatic logic is_svc(input logic [3:0] cls);
    return cls == 4'hF;
  endfunction
  function automatic logic is_cmp(input logic [3:0] opc);
    return opc >= OPC_CMP_LO && opc <= OPC_CMP_HI;
  endfunction
endpackage

// File: rtl/cpu_ctrl_fsm_cond_check.sv
// cond_check: ARM condition-code evaluation against {N,Z,C,V}; NV never passes.
module cond_check
  import cpu_ctrl_fsm_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;
  always_comb begin
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = n == v;
      COND_LT: pass = n != v;
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multicycle FETCH/DECODE/EXEC/WB sequencer with Moore strobes and a saturating retire counter.
module cpu_ctrl_fsm
  import cpu_ctrl_fsm_pkg::*;
(
  input  logic        CP,
  input  logic        reset,
  input  logic [31:0] IR,
  input  logic [3:0]  nzcv,
  output logic        writePC,
  output logic [1:0]  pcSel,
  output logic        writeIR,
  output logic        writeReg,
  output logic        regDstLR,
  output logic        writeNZCV,
  output logic [2:0]  state,
  output logic        done,
  output logic [7:0]  instrCount
);
  state_e     state_q;
  logic [7:0] cnt_q;
  logic       pass, dp, br, svc, link, cmp;
  logic       in_f, in_e, in_w;
  logic       unused_ir;
  cond_check u_cond (
    .cond (IR[31:28]),
    .nzcv (nzcv),
    .pass (pass)
  );
  assign dp        = is_dp(IR[27:24]);
  assign br        = is_br(IR[27:24]);
  assign svc       = is_svc(IR[27:24]);
  assign cmp       = is_cmp(IR[24:21]);
  assign link      = br & IR[24];
  assign unused_ir = ^IR[19:0];
  always_ff @(posedge CP) begin
    if (!reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        FETCH:   state_q <= DECODE;
        DECODE:  state_q <= (!pass || !(dp || br || svc)) ? FETCH : (svc ? HALT : EXEC);
        EXEC:    state_q <= WB;
        WB: begin
          state_q <= FETCH;
          cnt_q   <= cnt_q + {7'd0, cnt_q != 8'hFF};
        end
        HALT:    state_q <= HALT;
        default: state_q <= FETCH;
      endcase
    end
  end
  // Strobes are a pure decode of state and IR, gated off while reset is held low.
  assign in_f       = reset & (state_q == FETCH);
  assign in_e       = reset & (state_q == EXEC);
  assign in_w       = reset & (state_q == WB);
  assign writeIR    = in_f;
  assign writePC    = in_f | (in_w & br);
  assign pcSel      = (in_w & br) ? PC_BR : PC_INC;
  assign writeReg   = in_w & ((dp & ~cmp) | link);
  assign regDstLR   = in_w & link;
  assign writeNZCV  = in_e & dp & IR[20];
  assign done       = reset & (state_q == HALT);
  assign state      = state_q;
  assign instrCount = cnt_q;
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed plus randomized instruction stream checked against a behavioural sequencer model.
module tb_cpu_ctrl_fsm;
  logic        CP = 1'b0;
  logic        reset;
  logic [31:0] IR;
  logic [3:0]  nzcv;
  logic        writePC, writeIR, writeReg, regDstLR, writeNZCV, done;
  logic [1:0]  pcSel;
  logic [2:0]  state;
  logic [7:0]  instrCount;
  int          checks = 0;
  int          failures = 0;
  int          exp_cnt = 0;

  cpu_ctrl_fsm dut (
    .CP(CP), .reset(reset), .IR(IR), .nzcv(nzcv),
    .writePC(writePC), .pcSel(pcSel), .writeIR(writeIR), .writeReg(writeReg),
    .regDstLR(regDstLR), .writeNZCV(writeNZCV), .state(state), .done(done),
    .instrCount(instrCount)
  );

  always #5 CP = ~CP;

  function automatic bit arm_pass(input logic [3:0] c, input logic [3:0] f);
    bit n = f[3];
    bit z = f[2];
    bit cf = f[1];
    bit v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // 0 = data-processing, 1 = branch, 2 = SVC, 3 = undefined
  function automatic int kind(input logic [31:0] ir);
    if (ir[27:24] == 4'hF) return 2;
    if (ir[27:26] == 2'b00) return 0;
    if (ir[27:25] == 3'b101) return 1;
    return 3;
  endfunction

  // Expected {state, writePC, pcSel, writeIR, writeReg, regDstLR, writeNZCV, done} per phase.
  function automatic logic [10:0] model_outs(input int ph, input logic [31:0] ir);
    int k = kind(ir);
    bit link = (k == 1) && ir[24];
    bit cmpop = (ir[24:21] >= 4'd8) && (ir[24:21] <= 4'd11);
    bit wreg = ((k == 0) && !cmpop) || link;
    bit isbr = (k == 1);
    bit wflg = (k == 0) && ir[20];
    case (ph)
      0: return {3'd0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      1: return {3'd1, 8'd0};
      2: return {3'd2, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, wflg, 1'b0};
      3: return {3'd3, isbr, isbr ? 2'b01 : 2'b00, 1'b0, wreg, link, 1'b0, 1'b0};
      default: return {3'd4, 7'd0, 1'b1};
    endcase
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 3))
      0: r[27:26] = 2'b00;
      1: r[27:25] = 3'b101;
      default: ;
    endcase
    if (r[27:24] == 4'hF) r[27:24] = 4'h6;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [10:0] exp);
    chk(tag, {21'd0, state, writePC, pcSel, writeIR, writeReg, regDstLR, writeNZCV, done}, {21'd0, exp});
  endtask

  // Entered just after a negedge with the FSM in FETCH; leaves in FETCH (or HALT for a taken SVC).
  task automatic do_instr(input logic [31:0] ir, input logic [3:0] f);
    int k = kind(ir);
    bit go = arm_pass(ir[31:28], f) && (k != 3);
    IR = ir;
    nzcv = f;
    #1 chk_vec("fetch", model_outs(0, ir));
    @(negedge CP);
    #1 chk_vec("decode", model_outs(1, ir));
    chk("cnt_decode", {24'd0, instrCount}, exp_cnt);
    @(negedge CP);
    if (go && k == 2) return;
    if (go) begin
      nzcv = 4'($urandom);
      #1 chk_vec("exec", model_outs(2, ir));
      @(negedge CP);
      nzcv = 4'($urandom);
      #1 chk_vec("wb", model_outs(3, ir));
      @(negedge CP);
      if (exp_cnt < 255) exp_cnt++;
    end
    #1 chk("cnt_end", {24'd0, instrCount}, exp_cnt);
  endtask

  initial begin
    reset = 1'b0;
    IR = 32'h0;
    nzcv = 4'h0;
    repeat (2) @(negedge CP);
    #1 chk_vec("reset_outs", {3'd0, 8'd0});
    chk("reset_cnt", {24'd0, instrCount}, 0);
    reset = 1'b1;
    do_instr(32'hE0910002, 4'($urandom));
    do_instr(32'h01500001, 4'b0100);
    do_instr(32'h01500001, 4'b0000);
    do_instr(32'hEB000004, 4'($urandom));
    do_instr(32'hEA000004, 4'($urandom));
    do_instr(32'h0B000004, 4'b0100);
    do_instr(32'h1B000004, 4'b0100);
    do_instr(32'hE6000000, 4'($urandom));
    do_instr(32'hF0910002, 4'($urandom));
    do_instr(32'hE1A00001, 4'($urandom));
    for (int i = 0; i < 80; i++) do_instr(rand_ir(), 4'($urandom));
    IR = 32'hE0910002;
    nzcv = 4'h0;
    #1 chk_vec("abort_fetch", model_outs(0, IR));
    @(negedge CP);
    #1 chk_vec("abort_decode", model_outs(1, IR));
    @(negedge CP);
    #1 chk_vec("abort_exec", model_outs(2, IR));
    reset = 1'b0;
    #1 chk_vec("abort_forced", {3'd2, 8'd0});
    @(negedge CP);
    #1 chk_vec("abort_state", {3'd0, 8'd0});
    exp_cnt = 0;
    chk("abort_cnt", {24'd0, instrCount}, exp_cnt);
    reset = 1'b1;
    for (int i = 0; i < 300; i++) do_instr(32'hE0910002, 4'($urandom));
    chk("saturate", {24'd0, instrCount}, 255);
    do_instr(32'hEF000000, 4'($urandom));
    for (int i = 0; i < 100; i++) begin
      nzcv = 4'($urandom);
      #1 chk_vec("halt", model_outs(4, IR));
      chk("halt_cnt", {24'd0, instrCount}, exp_cnt);
      @(negedge CP);
    end
    reset = 1'b0;
    #1 chk_vec("halt_forced", {3'd4, 8'd0});
    @(negedge CP);
    #1 chk_vec("halt_reset", {3'd0, 8'd0});
    exp_cnt = 0;
    chk("halt_reset_cnt", {24'd0, instrCount}, exp_cnt);
    reset = 1'b1;
    do_instr(32'hE0910002, 4'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
